io_tx_port: RTL
===============

Name: io_tx_port

Overview:
- Memory-mapped byte-output peripheral downstream of the core's write port.
- Snoops every write beat (we, w_cnt, w_adr, w_dat) and pushes bytes that hit the TX data address into a FIFO.
- Drains the FIFO over a valid/ready byte stream.
- Produces rdy_o for the core's rdy_i so the core stalls before the FIFO overflows.

Parameters:
- TX_ADR, 16'hD000, byte address whose writes push into the FIFO.
- CTL_ADR, 16'hD001, control byte address: bit0 = clear FIFO, bit1 = clear overflow flag.
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- RDY_MARGIN, 2, rdy_o is deasserted when free slots <= RDY_MARGIN; range 1 to DEPTH-1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- we_i  in  1  write strobe from the core.
- w_cnt_i  in  2  bytes in this write: 0 = none, 1..3 = byte count.
- w_adr_i  in  16  address of byte 0.
- w_dat_i  in  24  write data; byte k is w_dat_i[8k+7:8k], written at (w_adr_i+k) mod 2^16.
- tx_rdy_i  in  1  sink accepts a byte this cycle.
- tx_vld_o  out  1  FIFO head is valid.
- tx_dat_o  out  8  FIFO head byte; 8'h00 when empty.
- rdy_o  out  1  core may proceed; drives core rdy_i.
- ovf_o  out  1  sticky flag: a push was dropped.
- cnt_o  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Pointers and count cleared, ovf_o=0, tx_vld_o=0, tx_dat_o=0, cnt_o=0, rdy_o=1.
  - Takes effect immediately, including mid-transfer; the write beat in flight is discarded.
- Beat decode, combinational, when we_i=1 and w_cnt_i!=0:
  - For k in 0..w_cnt_i-1, compute adr_k = w_adr_i+k with 16-bit wrap (FFFF+1 = 0000).
  - hit_tx when some adr_k == TX_ADR; push byte = that lane.
  - hit_ctl when some adr_k == CTL_ADR; ctl byte = that lane.
  - TX_ADR != CTL_ADR, so each hit matches at most one lane.
- Pop: pop = tx_vld_o & tx_rdy_i.
- Push:
  - Accepted when count < DEPTH, or when count == DEPTH and pop=1 in the same cycle.
  - When count == DEPTH and pop=0, the push is dropped and ovf_o is set at the next edge.
- Clear (ctl bit0=1), priority over everything:
  - At the next edge count=0, pointers=0; any same-cycle push or pop is ignored.
- Overflow clear (ctl bit1=1) clears ovf_o. If a drop occurs in the same cycle, the set wins.
- Latency: a pushed byte appears on tx_vld_o/tx_dat_o one cycle after the write beat.
  - Storage is register-based; tx_dat_o = mem[rd_ptr] when count != 0.
- Count update:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- rdy_o = (DEPTH - count) > RDY_MARGIN, computed from the registered count (combinational from state, no input paths).
- No read-back of registers; reads of TX_ADR and CTL_ADR are the Memory block's concern.
- Inputs are ignored when we_i=0.
- Writes whose lanes hit neither address have no effect.

Decomposition:
- Shared global-macros include gets the defaults IO_TX_ADR and IO_CTL_ADR, plus CTL bit indices IO_CTL_CLR=0 and IO_CTL_OVC=1.
- One natural sub-module: io_tx_fifo.
  - Parameterised DEPTH; push/pop/clear in; full/empty/count/head out.
  - The top holds the lane decode, ovf flag and rdy_o logic.

Test Plan (defaults unless stated):
1. Single push: we=1, cnt=1, adr=D000, dat=24'h000041 with tx_rdy=0.
   - Next cycle: vld=1, dat=41, cnt=1.
   - Raise tx_rdy for one cycle: cnt=0, vld=0, dat=00.
2. Multi-lane decode: cnt=3, adr=CFFF, dat=24'h0055AA (lanes CFFF=AA, D000=55, D001=00).
   - One push of 55; no clear.
   - Same test with dat=24'h0155AA: clear wins, cnt=0, 55 discarded.
3. Address wrap, with TX_ADR=16'h0000: cnt=3, adr=FFFE, dat=24'h770000.
   - Pushes 77.
   - Same with cnt=2: no push.
4. Backpressure and overflow: tx_rdy=0, push bytes 01..09 one per cycle.
   - rdy_o falls when cnt reaches 6.
   - cnt saturates at 8; byte 09 is dropped; ovf=1.
   - Drain order is 01..08.
5. Full push+pop: cnt=8, tx_rdy=1 while pushing 0A.
   - cnt stays 8; ovf unchanged; 0A drains last.
   - Then write CTL=02: ovf=0.
6. Async reset mid-stream: cnt=5, pull rst_i low between edges.
   - vld=0, cnt=0, rdy_o=1 immediately.
   - After release, a push of 3C appears after one cycle.

Source files
------------

// File: rtl/io_tx_port_pkg.sv
// Shared constants and the write-beat lane decoder for the byte-output peripheral.
package io_tx_port_pkg;

    localparam logic [15:0] IO_TX_ADR  = 16'hD000;
    localparam logic [15:0] IO_CTL_ADR = 16'hD001;
    localparam int unsigned IO_CTL_CLR = 0;
    localparam int unsigned IO_CTL_OVC = 1;

    typedef struct packed {
        logic       hit_tx;
        logic       hit_ctl;
        logic [7:0] tx_byte;
        logic [7:0] ctl_byte;
    } beat_dec_t;

    // Lane k lands at (adr + k) mod 2^16; at most one lane can match each address.
    function automatic beat_dec_t decode_beat(
        input logic        we,
        input logic [1:0]  cnt,
        input logic [15:0] adr,
        input logic [23:0] dat,
        input logic [15:0] tx_adr,
        input logic [15:0] ctl_adr
    );
        beat_dec_t   d;
        logic [15:0] lane_adr;
        d = '0;
        if (we) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (k < {30'd0, cnt}) begin
                    lane_adr = adr + 16'(k);
                    if (lane_adr == tx_adr) begin
                        d.hit_tx  = 1'b1;
                        d.tx_byte = dat[8*k +: 8];
                    end
                    if (lane_adr == ctl_adr) begin
                        d.hit_ctl  = 1'b1;
                        d.ctl_byte = dat[8*k +: 8];
                    end
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Register-based byte FIFO with synchronous clear; head reads 8'h00 when empty.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    input  logic [7:0]                 din_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic [7:0]                 head_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves this cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/io_tx_port.sv
// Memory-mapped byte-output port: snoops core write beats into a FIFO drained as a byte stream.
module io_tx_port
    import io_tx_port_pkg::*;
#(
    parameter logic [15:0] TX_ADR     = IO_TX_ADR,
    parameter logic [15:0] CTL_ADR    = IO_CTL_ADR,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RDY_MARGIN = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [1:0]             w_cnt_i,
    input  logic [15:0]            w_adr_i,
    input  logic [23:0]            w_dat_i,
    input  logic                   tx_rdy_i,
    output logic                   tx_vld_o,
    output logic [7:0]             tx_dat_o,
    output logic                   rdy_o,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    beat_dec_t     dec;
    logic          clr, ovc, pop, drop, full, empty;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt;

    assign dec = decode_beat(we_i, w_cnt_i, w_adr_i, w_dat_i, TX_ADR, CTL_ADR);
    assign clr = dec.hit_ctl & dec.ctl_byte[IO_CTL_CLR];
    assign ovc = dec.hit_ctl & dec.ctl_byte[IO_CTL_OVC];
    assign pop = tx_vld_o & tx_rdy_i;
    // A clear discards the same-cycle push, so it never counts as a drop.
    assign drop = dec.hit_tx & full & ~pop & ~clr;

    io_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (dec.hit_tx),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   (dec.tx_byte),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (cnt),
        .head_o  (tx_dat_o)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (ovc)  ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign tx_vld_o = ~empty;
    assign ovf_o    = ovf_q;
    assign cnt_o    = cnt;
    assign rdy_o    = (CW'(DEPTH) - cnt) > CW'(RDY_MARGIN);

endmodule
